// File: rtl/sr_mc_control.sv
// Multi-cycle control FSM for the schoolRISCV core: sequences FETCH/DECODE/EXEC/MEM/WB over
// one shared req/ack memory port, with sub-word lanes, misalignment and bus-timeout traps.
module sr_mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_SUBWORD  = 1'b1,
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] cmdOp,
  input  logic [2:0] cmdF3,
  input  logic [6:0] cmdF7,
  input  logic       aluZero,
  input  logic [1:0] addrLow,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic [3:0] mem_be,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] wdSrc,
  output logic [3:0] aluControl,
  output logic [1:0] ld_size,
  output logic       ld_uns,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
);

  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JAL = 2'd2, PC_JALR = 2'd3;
  localparam logic       ALUA_RS1 = 1'b0, ALUA_PC = 1'b1;
  localparam logic [1:0] ALUB_RS2 = 2'd0, ALUB_IMM_I = 2'd1, ALUB_IMM_S = 2'd2, ALUB_IMM_U = 2'd3;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PCPLUS4 = 2'd2, WD_IMMU = 2'd3;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            memGo_q, memGo_d;
  logic            trap_q, trap_d;
  logic [1:0]      cause_q, cause_d;

  logic isLoad, isStore, isBranch, isJal, isJalr, isLui, isAuipc, isOp, legal;
  logic condZero, misaligned, timeoutHit;
  logic [3:0] arithOp, branchOp;
  logic memReq, memWe, irW, pcW, regW;
  logic [3:0] be;

  assign isLoad   = (cmdOp == OP_LOAD);
  assign isStore  = (cmdOp == OP_STORE);
  assign isBranch = (cmdOp == OP_BRANCH);
  assign isJal    = (cmdOp == OP_JAL);
  assign isJalr   = (cmdOp == OP_JALR);
  assign isLui    = (cmdOp == OP_LUI);
  assign isAuipc  = (cmdOp == OP_AUIPC);
  assign isOp     = (cmdOp == OP_OP);

  // BEQ/BGE/BGEU take the branch when the compare result is zero
  assign condZero   = cmdF3[2] ? cmdF3[0] : ~cmdF3[0];
  assign branchOp   = (cmdF3[2:1] == 2'b00) ? ALU_SUB : (cmdF3[1] ? ALU_SLTU : ALU_SLT);
  assign misaligned = ((cmdF3[1:0] == 2'b10) && (addrLow != 2'b00)) ||
                      ((cmdF3[1:0] == 2'b01) && addrLow[0]);
  assign timeoutHit = (cnt_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    legal = 1'b0;
    case (cmdOp)
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:   legal = (cmdF3 == 3'b000);
      OP_BRANCH: legal = (cmdF3[2:1] != 2'b01);
      OP_LOAD:   legal = (cmdF3 == 3'b010) ||
                         (EN_SUBWORD && ((cmdF3[1:0] == 2'b00) || (cmdF3 == 3'b001) || (cmdF3 == 3'b101)));
      OP_STORE:  legal = (cmdF3 == 3'b010) || (EN_SUBWORD && (cmdF3[2:1] == 2'b00));
      OP_IMM: begin
        if (cmdF3 == 3'b001)      legal = (cmdF7 == 7'h00);
        else if (cmdF3 == 3'b101) legal = (cmdF7 == 7'h00) || (cmdF7 == 7'h20);
        else                      legal = 1'b1;
      end
      OP_OP:     legal = (cmdF7 == 7'h00) || ((cmdF7 == 7'h20) && ((cmdF3 == 3'b000) || (cmdF3 == 3'b101)));
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    arithOp = ALU_ADD;
    case (cmdF3)
      3'b000:  arithOp = (isOp && cmdF7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  arithOp = ALU_SLL;
      3'b010:  arithOp = ALU_SLT;
      3'b011:  arithOp = ALU_SLTU;
      3'b100:  arithOp = ALU_XOR;
      3'b101:  arithOp = cmdF7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  arithOp = ALU_OR;
      default: arithOp = ALU_AND;
    endcase
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; memGo_d = memGo_q; trap_d = trap_q; cause_d = cause_q;
    memReq = 1'b0; memWe = 1'b0; be = 4'b0000; irW = 1'b0; pcW = 1'b0; regW = 1'b0;
    pcSrc = PC_PLUS4; aluSrcA = ALUA_RS1; aluSrcB = ALUB_RS2; wdSrc = WD_ALU;
    aluControl = ALU_ADD; ld_size = 2'd0; ld_uns = 1'b0;
    case (state_q)
      S_FETCH: begin
        memReq = 1'b1;
        if (mem_ack) begin
          irW = 1'b1; cnt_d = '0; state_d = S_DECODE;
        end else if (timeoutHit) begin
          state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'd3;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = '0;
        if (isLoad || isStore) begin
          aluSrcB = isStore ? ALUB_IMM_S : ALUB_IMM_I;
          memGo_d = 1'b0; state_d = S_MEM;
        end else begin
          pcW = 1'b1; state_d = S_FETCH;
          if (isBranch) begin
            aluControl = branchOp;
            pcSrc = (aluZero == condZero) ? PC_BRANCH : PC_PLUS4;
          end else if (isJal || isJalr) begin
            regW = 1'b1; wdSrc = WD_PCPLUS4;
            pcSrc = isJal ? PC_JAL : PC_JALR;
            aluSrcB = ALUB_IMM_I;
          end else if (isLui) begin
            regW = 1'b1; wdSrc = WD_IMMU;
          end else if (isAuipc) begin
            regW = 1'b1; aluSrcA = ALUA_PC; aluSrcB = ALUB_IMM_U;
          end else begin
            regW = 1'b1; aluControl = arithOp;
            aluSrcB = isOp ? ALUB_RS2 : ALUB_IMM_I;
          end
        end
      end
      S_MEM: begin
        aluSrcB = isStore ? ALUB_IMM_S : ALUB_IMM_I;
        // First MEM cycle only checks alignment; the request starts on the next one
        if (!memGo_q) begin
          if (misaligned) begin
            state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'd2;
          end else begin
            memGo_d = 1'b1;
          end
        end else begin
          memReq = 1'b1;
          memWe  = isStore;
          if (isStore) begin
            case (cmdF3[1:0])
              2'b00:   be = 4'b0001 << addrLow;
              2'b01:   be = 4'b0011 << addrLow;
              default: be = 4'b1111;
            endcase
          end
          if (mem_ack) begin
            memGo_d = 1'b0; cnt_d = '0;
            if (isStore) begin
              pcW = 1'b1; state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (timeoutHit) begin
            state_d = S_TRAP; trap_d = 1'b1; cause_d = 2'd3;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end
      S_WB: begin
        regW = 1'b1; wdSrc = WD_MEM; ld_size = cmdF3[1:0]; ld_uns = cmdF3[2];
        pcW = 1'b1; cnt_d = '0; state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      memGo_q <= 1'b0;
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      memGo_q <= memGo_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Strobes are forced low for the whole time reset is asserted, not just after the next edge
  assign mem_req    = memReq & rst_n;
  assign mem_we     = memWe & rst_n;
  assign mem_be     = be & {4{rst_n}};
  assign irWrite    = irW & rst_n;
  assign pcWrite    = pcW & rst_n;
  assign regWrite   = regW & rst_n;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sr_mc_control.sv
// Directed bench for sr_mc_control: each task walks one instruction scenario cycle by cycle
// and compares the control outputs against hand-derived values.
module tb_sr_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] cmdOp = 7'd0;
  logic [2:0] cmdF3 = 3'd0;
  logic [6:0] cmdF7 = 7'd0;
  logic       aluZero = 1'b0;
  logic [1:0] addrLow = 2'd0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, irWrite, pcWrite, regWrite, aluSrcA, ld_uns, trap;
  logic [3:0] mem_be, aluControl;
  logic [1:0] pcSrc, aluSrcB, wdSrc, ld_size, trap_cause;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] OP_JAL = 7'b1101111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011;

  sr_mc_control dut (
    .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
    .aluZero(aluZero), .addrLow(addrLow), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .wdSrc(wdSrc),
    .aluControl(aluControl), .ld_size(ld_size), .ld_uns(ld_uns), .trap(trap),
    .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0; mem_ack = 1'b0; aluZero = 1'b0; addrLow = 2'd0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Fetch with an immediate ack, pass DECODE, and return sitting in the cycle after DECODE
  task automatic goExec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cmdOp = op; cmdF3 = f3; cmdF7 = f7; mem_ack = 1'b1;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req got=%0h exp=0", mem_req); end
    checks++; if (irWrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_irWrite got=%0h exp=0", irWrite); end
    checks++; if (state_o !== 3'd0) begin failures++; $display("[TB] FAIL reset_state got=%0h exp=0", state_o); end
    checks++; if (trap !== 1'b0) begin failures++; $display("[TB] FAIL reset_trap got=%0h exp=0", trap); end
    checks++; if (trap_cause !== 2'd0) begin failures++; $display("[TB] FAIL reset_cause got=%0h exp=0", trap_cause); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL release_mem_req got=%0h exp=1", mem_req); end
  endtask

  task automatic test_addi();
    cmdOp = OP_IMM; cmdF3 = 3'd0; cmdF7 = 7'd0; mem_ack = 1'b1; #1;
    checks++; if (irWrite !== 1'b1) begin failures++; $display("[TB] FAIL addi_irWrite got=%0h exp=1", irWrite); end
    nextCycle(); mem_ack = 1'b0; #1;
    checks++; if (state_o !== 3'd1) begin failures++; $display("[TB] FAIL addi_decode_state got=%0h exp=1", state_o); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL addi_decode_req got=%0h exp=0", mem_req); end
    nextCycle();
    checks++; if (state_o !== 3'd2) begin failures++; $display("[TB] FAIL addi_exec_state got=%0h exp=2", state_o); end
    checks++; if (regWrite !== 1'b1) begin failures++; $display("[TB] FAIL addi_regWrite got=%0h exp=1", regWrite); end
    checks++; if (pcWrite !== 1'b1) begin failures++; $display("[TB] FAIL addi_pcWrite got=%0h exp=1", pcWrite); end
    checks++; if (pcSrc !== 2'd0) begin failures++; $display("[TB] FAIL addi_pcSrc got=%0h exp=0", pcSrc); end
    checks++; if (aluSrcB !== 2'd1) begin failures++; $display("[TB] FAIL addi_aluSrcB got=%0h exp=1", aluSrcB); end
    checks++; if (aluControl !== 4'd0) begin failures++; $display("[TB] FAIL addi_aluControl got=%0h exp=0", aluControl); end
    nextCycle();
    checks++; if (state_o !== 3'd0) begin failures++; $display("[TB] FAIL addi_back_fetch got=%0h exp=0", state_o); end
  endtask

  // BEQ z=1/0, BNE z=1/0, BGE z=1, BLT z=1
  logic [2:0] brF3   [6] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b101, 3'b100};
  logic       brZero [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [1:0] brPc   [6] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
  logic [3:0] brAlu  [6] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd3, 4'd3};

  task automatic test_branch();
    for (int i = 0; i < 6; i++) begin
      aluZero = brZero[i];
      goExec(OP_BRANCH, brF3[i], 7'd0);
      checks++; if (pcSrc !== brPc[i]) begin failures++; $display("[TB] FAIL branch%0d_pcSrc got=%0h exp=%0h", i, pcSrc, brPc[i]); end
      checks++; if (pcWrite !== 1'b1) begin failures++; $display("[TB] FAIL branch%0d_pcWrite got=%0h exp=1", i, pcWrite); end
      checks++; if (regWrite !== 1'b0) begin failures++; $display("[TB] FAIL branch%0d_regWrite got=%0h exp=0", i, regWrite); end
      checks++; if (aluControl !== brAlu[i]) begin failures++; $display("[TB] FAIL branch%0d_alu got=%0h exp=%0h", i, aluControl, brAlu[i]); end
      nextCycle();
    end
    aluZero = 1'b0;
  endtask

  task automatic test_jal();
    goExec(OP_JAL, 3'd0, 7'd0);
    checks++; if (regWrite !== 1'b1) begin failures++; $display("[TB] FAIL jal_regWrite got=%0h exp=1", regWrite); end
    checks++; if (wdSrc !== 2'd2) begin failures++; $display("[TB] FAIL jal_wdSrc got=%0h exp=2", wdSrc); end
    checks++; if (pcSrc !== 2'd2) begin failures++; $display("[TB] FAIL jal_pcSrc got=%0h exp=2", pcSrc); end
    checks++; if (pcWrite !== 1'b1) begin failures++; $display("[TB] FAIL jal_pcWrite got=%0h exp=1", pcWrite); end
    nextCycle();
  endtask

  // SB @3, SH @2, SW @0
  logic [2:0] stF3   [3] = '{3'b000, 3'b001, 3'b010};
  logic [1:0] stAddr [3] = '{2'd3, 2'd2, 2'd0};
  logic [3:0] stBe   [3] = '{4'b1000, 4'b1100, 4'b1111};

  task automatic test_store();
    for (int i = 0; i < 3; i++) begin
      addrLow = stAddr[i];
      goExec(OP_STORE, stF3[i], 7'd0);
      checks++; if (aluSrcB !== 2'd2) begin failures++; $display("[TB] FAIL st%0d_exec_aluSrcB got=%0h exp=2", i, aluSrcB); end
      checks++; if (pcWrite !== 1'b0) begin failures++; $display("[TB] FAIL st%0d_exec_pcWrite got=%0h exp=0", i, pcWrite); end
      nextCycle();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL st%0d_check_req got=%0h exp=0", i, mem_req); end
      nextCycle();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL st%0d_req got=%0h exp=1", i, mem_req); end
      checks++; if (mem_we !== 1'b1) begin failures++; $display("[TB] FAIL st%0d_we got=%0h exp=1", i, mem_we); end
      checks++; if (mem_be !== stBe[i]) begin failures++; $display("[TB] FAIL st%0d_be got=%0h exp=%0h", i, mem_be, stBe[i]); end
      mem_ack = 1'b1; #1;
      checks++; if (pcWrite !== 1'b1) begin failures++; $display("[TB] FAIL st%0d_ack_pcWrite got=%0h exp=1", i, pcWrite); end
      nextCycle(); mem_ack = 1'b0; #1;
      checks++; if (state_o !== 3'd0) begin failures++; $display("[TB] FAIL st%0d_back_fetch got=%0h exp=0", i, state_o); end
    end
  endtask

  task automatic test_sh_misaligned();
    addrLow = 2'd1;
    goExec(OP_STORE, 3'b001, 7'd0);
    nextCycle();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL mis_check_req got=%0h exp=0", mem_req); end
    nextCycle();
    checks++; if (state_o !== 3'd5) begin failures++; $display("[TB] FAIL mis_state got=%0h exp=5", state_o); end
    checks++; if (trap !== 1'b1) begin failures++; $display("[TB] FAIL mis_trap got=%0h exp=1", trap); end
    checks++; if (trap_cause !== 2'd2) begin failures++; $display("[TB] FAIL mis_cause got=%0h exp=2", trap_cause); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL mis_trap_req got=%0h exp=0", mem_req); end
    applyReset();
  endtask

  task automatic test_lw_delay();
    int reqCycles = 0;
    addrLow = 2'd0;
    goExec(OP_LOAD, 3'b010, 7'd0);
    nextCycle();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL lw_check_req got=%0h exp=0", mem_req); end
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      mem_ack = (i == 5); #1;
      if (mem_req === 1'b1) reqCycles++;
    end
    checks++; if (reqCycles !== 6) begin failures++; $display("[TB] FAIL lw_req_cycles got=%0d exp=6", reqCycles); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL lw_we got=%0h exp=0", mem_we); end
    nextCycle(); mem_ack = 1'b0; #1;
    checks++; if (state_o !== 3'd4) begin failures++; $display("[TB] FAIL lw_wb_state got=%0h exp=4", state_o); end
    checks++; if (regWrite !== 1'b1) begin failures++; $display("[TB] FAIL lw_regWrite got=%0h exp=1", regWrite); end
    checks++; if (wdSrc !== 2'd1) begin failures++; $display("[TB] FAIL lw_wdSrc got=%0h exp=1", wdSrc); end
    checks++; if (ld_size !== 2'd2) begin failures++; $display("[TB] FAIL lw_ld_size got=%0h exp=2", ld_size); end
    checks++; if (ld_uns !== 1'b0) begin failures++; $display("[TB] FAIL lw_ld_uns got=%0h exp=0", ld_uns); end
    checks++; if (pcWrite !== 1'b1) begin failures++; $display("[TB] FAIL lw_pcWrite got=%0h exp=1", pcWrite); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL lw_wb_req got=%0h exp=0", mem_req); end
    nextCycle();
    checks++; if (state_o !== 3'd0) begin failures++; $display("[TB] FAIL lw_back_fetch got=%0h exp=0", state_o); end
  endtask

  task automatic test_timeout();
    applyReset();
    mem_ack = 1'b0;
    repeat (15) nextCycle();
    checks++; if (state_o !== 3'd0) begin failures++; $display("[TB] FAIL to15_state got=%0h exp=0", state_o); end
    checks++; if (trap !== 1'b0) begin failures++; $display("[TB] FAIL to15_trap got=%0h exp=0", trap); end
    nextCycle();
    checks++; if (state_o !== 3'd5) begin failures++; $display("[TB] FAIL to16_state got=%0h exp=5", state_o); end
    checks++; if (trap_cause !== 2'd3) begin failures++; $display("[TB] FAIL to16_cause got=%0h exp=3", trap_cause); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL to16_req got=%0h exp=0", mem_req); end
    mem_ack = 1'b1;
    repeat (3) nextCycle();
    checks++; if (trap !== 1'b1) begin failures++; $display("[TB] FAIL to_sticky_trap got=%0h exp=1", trap); end
    checks++; if (trap_cause !== 2'd3) begin failures++; $display("[TB] FAIL to_sticky_cause got=%0h exp=3", trap_cause); end
    checks++; if (irWrite !== 1'b0) begin failures++; $display("[TB] FAIL to_sticky_irWrite got=%0h exp=0", irWrite); end
    mem_ack = 1'b0;
  endtask

  task automatic test_ack_last();
    applyReset();
    repeat (15) nextCycle();
    mem_ack = 1'b1; #1;
    checks++; if (irWrite !== 1'b1) begin failures++; $display("[TB] FAIL acklast_irWrite got=%0h exp=1", irWrite); end
    nextCycle(); mem_ack = 1'b0; #1;
    checks++; if (state_o !== 3'd1) begin failures++; $display("[TB] FAIL acklast_state got=%0h exp=1", state_o); end
    checks++; if (trap !== 1'b0) begin failures++; $display("[TB] FAIL acklast_trap got=%0h exp=0", trap); end
  endtask

  task automatic test_illegal();
    applyReset();
    goExec(7'h7F, 3'd0, 7'd0);
    checks++; if (state_o !== 3'd5) begin failures++; $display("[TB] FAIL ill_state got=%0h exp=5", state_o); end
    checks++; if (trap_cause !== 2'd1) begin failures++; $display("[TB] FAIL ill_cause got=%0h exp=1", trap_cause); end
    mem_ack = 1'b1;
    repeat (4) nextCycle();
    checks++; if (trap !== 1'b1) begin failures++; $display("[TB] FAIL ill_sticky_trap got=%0h exp=1", trap); end
    checks++; if (trap_cause !== 2'd1) begin failures++; $display("[TB] FAIL ill_sticky_cause got=%0h exp=1", trap_cause); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL ill_req got=%0h exp=0", mem_req); end
    checks++; if (regWrite !== 1'b0) begin failures++; $display("[TB] FAIL ill_regWrite got=%0h exp=0", regWrite); end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    applyReset();
    addrLow = 2'd0;
    goExec(OP_LOAD, 3'b010, 7'd0);
    nextCycle();
    nextCycle();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rmm_req got=%0h exp=1", mem_req); end
    #1 rst_n = 1'b0; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rmm_req_low got=%0h exp=0", mem_req); end
    checks++; if (state_o !== 3'd0) begin failures++; $display("[TB] FAIL rmm_state got=%0h exp=0", state_o); end
    #1 rst_n = 1'b1; #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rmm_refetch got=%0h exp=1", mem_req); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jal();
    test_store();
    test_sh_misaligned();
    test_lw_delay();
    test_timeout();
    test_ack_last();
    test_illegal();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
